// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Multi-cycle data-memory target for the core's load/store port. One word
// access is accepted at a time over a valid/ready request channel. It is
// held for LATENCY wait states and then answered over a valid/ready response
// channel: read data for loads, or an acknowledgement (rdata = 0) for stores.
//
// Parameters:
//   DEPTH    number of 32-bit words (power of two, >= 4)
//   LATENCY  wait-state cycles between acceptance and response (0..15)
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_valid_i  request present
//   req_ready_o  responder can take a request this cycle
//   req_we_i     1 = write, 0 = read
//   req_addr_i   byte address (word index = addr[log2(DEPTH)+1:2])
//   req_wdata_i  write data
//   req_wstrb_i  byte enables, bit i covers wdata[8i+7:8i]
//   rsp_valid_o  response present
//   rsp_ready_i  initiator takes the response
//   rsp_rdata_o  read data, 0 for write responses
//   rsp_err_o    access error flag
//
// Optional feature, macro DMEM_RESPONDER_ERR_EN:
//   when defined, misaligned or out-of-range addresses are flagged as errors,
//   do not touch memory and return rdata = 0. When undefined, rsp_err_o is
//   tied to 0 and addresses wrap modulo DEPTH*4.
// ---------------------------------------------------------------------------
module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_wstrb_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int IdxW = $clog2(DEPTH);
   localparam logic [3:0] CntLoad = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_e;

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              we_q;
   logic [3:0]        wstrb_q;
   logic [31:0]       wdata_q;
   logic [IdxW-1:0]   idx_q;
   logic [31:0]       rsp_rdata_q;

   logic [31:0]       mem [DEPTH];

   logic              accept;
   logic              commit;
   logic [IdxW-1:0]   reqIdx;
   logic              reqErr;
   logic              accWe;
   logic [3:0]        accWstrb;
   logic [31:0]       accWdata;
   logic [IdxW-1:0]   accIdx;
   logic              accErr;
   logic [31:0]       rsp_rdata_d;

   assign reqIdx = req_addr_i[IdxW+1:2];

`ifdef DMEM_RESPONDER_ERR_EN
   logic err_q;
   logic rsp_err_q;

   // Misaligned, or any address bit above the memory window set.
   assign reqErr = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:IdxW+2] != '0);
`else
   logic unusedAddrBits;

   assign reqErr         = 1'b0;
   assign unusedAddrBits = ^{req_addr_i[31:IdxW+2], req_addr_i[1:0]};
`endif

   // Ready is gated by reset so it rises combinationally on release.
   assign req_ready_o = rst_ni && (state_q == IDLE);
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_rdata_o = rsp_rdata_q;
   assign accept      = req_valid_i && req_ready_o;

   // With zero wait states the access happens on the accepting edge itself,
   // so it must use the live request; otherwise it uses the captured copy.
   assign accWe    = (LATENCY == 0) ? req_we_i    : we_q;
   assign accWstrb = (LATENCY == 0) ? req_wstrb_i : wstrb_q;
   assign accWdata = (LATENCY == 0) ? req_wdata_i : wdata_q;
   assign accIdx   = (LATENCY == 0) ? reqIdx      : idx_q;
`ifdef DMEM_RESPONDER_ERR_EN
   assign accErr   = (LATENCY == 0) ? reqErr      : err_q;
`else
   assign accErr   = reqErr;
`endif

   // The commit edge is the one that moves the FSM into RESP.
   assign commit = (LATENCY == 0) ? accept : ((state_q == BUSY) && (cnt_q == 4'd0));

   // Response data: memory word for a good read, zero for writes and errors.
   always_comb begin
      rsp_rdata_d = 32'd0;
      if (!accWe && !accErr) begin
         rsp_rdata_d = mem[accIdx];
      end
   end

   // Storage array has no reset; only enabled bytes of a good write change.
   always_ff @(posedge clk_i) begin
      if (commit && accWe && !accErr) begin
         for (int b = 0; b < 4; b++) begin
            if (accWstrb[b]) begin
               mem[accIdx][8*b +: 8] <= accWdata[8*b +: 8];
            end
         end
      end
   end

   // Transaction FSM: capture on accept, count wait states, hold the
   // registered response until the initiator takes it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         wstrb_q     <= 4'd0;
         wdata_q     <= 32'd0;
         idx_q       <= '0;
         rsp_rdata_q <= 32'd0;
`ifdef DMEM_RESPONDER_ERR_EN
         err_q       <= 1'b0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  we_q    <= req_we_i;
                  wstrb_q <= req_wstrb_i;
                  wdata_q <= req_wdata_i;
                  idx_q   <= reqIdx;
`ifdef DMEM_RESPONDER_ERR_EN
                  err_q   <= reqErr;
`endif
                  cnt_q   <= CntLoad;
                  state_q <= (LATENCY == 0) ? RESP : BUSY;
               end
            end
            BUSY: begin
               if (cnt_q == 4'd0) begin
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase

         if (commit) begin
            rsp_rdata_q <= rsp_rdata_d;
`ifdef DMEM_RESPONDER_ERR_EN
            rsp_err_q   <= accErr;
`endif
         end
      end
   end

`ifdef DMEM_RESPONDER_ERR_EN
   assign rsp_err_o = rsp_err_q;
`else
   assign rsp_err_o = 1'b0;
`endif

endmodule

// File: doc/dmem_responder.md
# dmem_responder

- Multi-cycle data-memory target with a valid/ready request channel and a valid/ready response channel.
- Sits at the far end of the core's load/store port. It accepts one word access at a time, holds it for a programmable number of wait states, then returns read data or a write acknowledgement.
- Replaces the zero-latency data memory when the core is moved to a handshaked memory bus, and serves as the bus model for that bus.

## Interface
- `DEPTH`, 256: number of 32-bit words stored; must be a power of two, ≥4.
- `LATENCY`, 2: wait-state cycles between request acceptance and response; range 0..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  initiator presents a request.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  write data.
- `req_wstrb`  in  4  byte enables; bit i covers `wdata[8i+7:8i]`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  initiator accepts the response.
- `rsp_rdata`  out  32  read data; 0 for write responses.
- `rsp_err`  out  1  access error (see Configuration).

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, the request is accepted: capture `req_we`, `req_wstrb`, `req_wdata` and the word index. Go to BUSY if `LATENCY`>0, otherwise RESP. The wait counter loads `LATENCY`-1.
  - BUSY: the counter decrements each cycle. At 0, perform the access and go to RESP.
  - RESP: `rsp_valid`=1, and `rsp_rdata`/`rsp_err` are held stable. On `rsp_ready`, go to IDLE.
- The access is performed on the edge that enters RESP.
  - Write: update only the bytes whose strobe is 1. Strobe 4'b0000 is a legal no-op that still gets a response.
  - Read: register `mem[idx]` into `rsp_rdata`.
- Word index = `req_addr[log2(DEPTH)+1:2]`.
  - Upper address bits are ignored, so accesses wrap modulo `DEPTH`*4.
  - `req_addr[1:0]` is ignored.
- `req_addr`, `req_wdata`, `req_wstrb` and `req_we` are don't-care once accepted. Changes after acceptance do not affect the transaction.
- Only one transaction is outstanding. `req_ready`=0 in BUSY and RESP; a `req_valid` held during those states waits.
- A read issued after a write response has completed returns the written data.
- Memory contents are not reset. The bench initialises them by writes only.

## Timing
- Reset (`rst`=0), asynchronous: state=IDLE, counter=0, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `req_ready` is forced to 0 while `rst`=0 and rises combinationally once `rst`=1.
- Request accepted at rising edge t:
  - `rsp_valid` is high in the cycle after edge t+`LATENCY`.
  - `LATENCY`=0 gives `rsp_valid` in the cycle right after t.
- Response completed at edge u (`rsp_valid`&`rsp_ready`): `req_ready`=1 in the cycle after u. There is no same-cycle turnaround.
- Back-to-back throughput: one transaction per `LATENCY`+2 cycles when `rsp_ready` is held high.
- `rsp_ready` high while `rsp_valid`=0 has no effect.
- Reset mid-transaction:
  - The transaction is abandoned and no response is issued.
  - A write whose commit edge has not yet occurred is not performed.
  - A reset asserted in RESP leaves the already-committed write in memory.
- `req_ready` and `rsp_valid` are direct decodes of the state register. There is no combinational path from `req_valid` or `rsp_ready` to any output.

## Configuration
- Macro `DMEM_RESPONDER_ERR_EN`.
- Defined: a request is an error if `req_addr[1:0]`≠0, or if `req_addr` ≥ `DEPTH`*4.
  - The error is evaluated on accepted inputs.
  - An error write does not modify memory.
  - An error read returns `rsp_rdata`=0.
  - Both return `rsp_err`=1 with normal timing.
  - Non-error accesses return `rsp_err`=0.
  - Wrap-around does not occur.
- Undefined: `rsp_err` is constant 0, the address is truncated and wraps as described in Operation, and no error logic is synthesised.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `req_valid`=1.
  - Expect all outputs 0 throughout.
  - Release: `req_ready`=1 and the request is accepted on the first edge.
- Write then read, `LATENCY`=2, `rsp_ready`=1:
  - Write 0xDEADBEEF to 0x10 with strobe 4'hF; `rsp_valid` appears 2 cycles after acceptance with `rsp_rdata`=0.
  - Read 0x10 returns 0xDEADBEEF.
- Byte strobes:
  - Write 0x11223344 to 0x20 with strobe 4'hF, then 0xAABBCCDD with strobe 4'b0101.
  - Read returns 0x11BB33DD.
- Backpressure:
  - Hold `rsp_ready`=0 for 5 cycles during a read response; `rsp_valid` and `rsp_rdata` stay stable.
  - `req_ready` stays 0 while a second `req_valid` waits; the second request is accepted the cycle after the handshake.
- `LATENCY`=0 back-to-back: 4 reads with `rsp_ready`=1 complete in 8 cycles.
  - `rsp_valid` is high 1 cycle after each acceptance.
- Wrap/error, `DEPTH`=256:
  - Write 0x5A5A5A5A to 0x400.
  - Without the macro, a read of 0x0 returns 0x5A5A5A5A.
  - With `DMEM_RESPONDER_ERR_EN`: `rsp_err`=1, address 0x0 is unchanged, and a read of 0x2 gives `rsp_err`=1 with `rsp_rdata`=0.
